// File: rtl/penc_pkg.sv
// ============================================================================
// Module : penc_pkg
// Brief  : Shared constants and helpers for the rr_priority_encoder block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package penc_pkg;

   localparam int PENC_FIXED     = 0;
   localparam int PENC_RR        = 1;
   localparam int PENC_DEFAULT_N = 8;

   // Minimum of 1 so a 2-input encoder still has a 1-bit index.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

`default_nettype wire

// File: rtl/penc_core.sv
// ============================================================================
// Module : penc_core
// Brief  : Combinational highest-set-bit finder returning index and found flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module penc_core #(
   parameter int N    = 8,
   parameter int IDXW = 3
) (
   input  logic [N-1:0]    vec,
   output logic [IDXW-1:0] idx,
   output logic            found
);

   // Ascending scan: the last set bit seen is the highest one.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx   = IDXW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rr_priority_encoder.sv
// ============================================================================
// Module : rr_priority_encoder
// Brief  : Registered N-input priority encoder, fixed or round-robin, with a
//          valid/ready output. Macro PENC_STICKY_EN adds a pending register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_priority_encoder
   import penc_pkg::*;
#(
   parameter int N    = PENC_DEFAULT_N,
   parameter int RR   = PENC_FIXED,
   parameter int IDXW = clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [IDXW-1:0] out_idx,
   output logic [N-1:0]    out_onehot,
   output logic            any_req
);

   logic [N-1:0]    eff;
   logic [N-1:0]    core_in;
   logic [N-1:0]    win_onehot;
   logic [IDXW-1:0] core_idx;
   logic [IDXW-1:0] winner;
   logic            core_found;
   logic            load;

   assign load       = !out_valid || out_ready;
   assign win_onehot = {{(N-1){1'b0}}, 1'b1} << winner;

`ifdef PENC_STICKY_EN
   logic [N-1:0] pending;
   logic [N-1:0] issue_onehot;

   assign eff          = pending | req;
   assign issue_onehot = (load && core_found) ? win_onehot : '0;

   // A bit issued this cycle is consumed even if its req is still high.
   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= (pending | req) & ~issue_onehot;
   end
`else
   assign eff = req;
`endif

   penc_core #(
      .N    (N),
      .IDXW (IDXW)
   ) u_core (
      .vec   (core_in),
      .idx   (core_idx),
      .found (core_found)
   );

   generate
      if (RR == PENC_RR) begin : g_rr
         logic [IDXW-1:0] ptr;

         // Rotate so that eff[ptr] lands on the MSB and the descending search
         // order (ptr, ptr-1, ..., 0, N-1, ...) becomes plain MSB-first.
         always_comb begin
            int src;
            core_in = '0;
            for (int j = 0; j < N; j++) begin
               src = int'(ptr) - j;
               if (src < 0) src = src + N;
               core_in[N-1-j] = eff[src];
            end
         end

         always_comb begin
            int src;
            src = int'(ptr) - (N - 1 - int'(core_idx));
            if (src < 0) src = src + N;
            winner = src[IDXW-1:0];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               ptr <= IDXW'(N - 1);
            end else if (load && core_found) begin
               ptr <= (winner == '0) ? IDXW'(N - 1) : winner - 1'b1;
            end
         end
      end else begin : g_fixed
         assign core_in = eff;
         assign winner  = core_idx;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_onehot <= '0;
         any_req    <= 1'b0;
      end else begin
         any_req <= |eff;
         if (load) begin
            if (core_found) begin
               out_valid  <= 1'b1;
               out_idx    <= winner;
               out_onehot <= win_onehot;
            end else begin
               out_valid  <= 1'b0;
               out_idx    <= '0;
               out_onehot <= '0;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rr_priority_encoder.sv
// ============================================================================
// Module : tb_rr_priority_encoder
// Brief  : Directed bench driving a fixed and a round-robin instance together.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_priority_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       out_ready;

   logic       f_valid, f_any, r_valid, r_any;
   logic [2:0] f_idx, r_idx;
   logic [7:0] f_oh, r_oh;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rr_priority_encoder #(.N(8), .RR(0)) dut_fix (
      .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
      .out_valid(f_valid), .out_idx(f_idx), .out_onehot(f_oh), .any_req(f_any)
   );

   rr_priority_encoder #(.N(8), .RR(1)) dut_rr (
      .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
      .out_valid(r_valid), .out_idx(r_idx), .out_onehot(r_oh), .any_req(r_any)
   );

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; out_ready = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 8'hFF; out_ready = 1'b1;
      step();
      step();
      checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL reset_f_valid got=%0b exp=0", f_valid); end
      checks++; if (f_idx !== 3'd0) begin failures++; $display("FAIL reset_f_idx got=%0d exp=0", f_idx); end
      checks++; if (f_oh !== 8'h00) begin failures++; $display("FAIL reset_f_onehot got=%h exp=00", f_oh); end
      checks++; if (f_any !== 1'b0) begin failures++; $display("FAIL reset_f_any got=%0b exp=0", f_any); end
      checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL reset_r_valid got=%0b exp=0", r_valid); end
      rst = 1'b0; req = '0;
   endtask

   task automatic test_fixed();
      do_reset();
      req = 8'b0011_1100; out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if (f_valid !== 1'b1) begin failures++; $display("FAIL fixed_valid c=%0d got=%0b exp=1", c, f_valid); end
         checks++; if (f_idx !== 3'd5) begin failures++; $display("FAIL fixed_idx c=%0d got=%0d exp=5", c, f_idx); end
         checks++; if (f_oh !== 8'b0010_0000) begin failures++; $display("FAIL fixed_onehot c=%0d got=%b exp=00100000", c, f_oh); end
         checks++; if (f_any !== 1'b1) begin failures++; $display("FAIL fixed_any c=%0d got=%0b exp=1", c, f_any); end
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_seq [6];
      exp_seq = '{3'd7, 3'd5, 3'd2, 3'd7, 3'd5, 3'd2};
      do_reset();
      req = 8'b1010_0100; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         checks++; if (r_idx !== exp_seq[c]) begin failures++; $display("FAIL rr_idx c=%0d got=%0d exp=%0d", c, r_idx, exp_seq[c]); end
         checks++; if (r_oh !== (8'd1 << exp_seq[c])) begin failures++; $display("FAIL rr_onehot c=%0d got=%b exp=%b", c, r_oh, 8'd1 << exp_seq[c]); end
      end
      // A lone request is re-granted every cycle in round-robin mode too.
      req = 8'b0000_1000;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if (r_idx !== 3'd3 || r_valid !== 1'b1) begin failures++; $display("FAIL rr_single c=%0d got_idx=%0d got_valid=%0b exp_idx=3 exp_valid=1", c, r_idx, r_valid); end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0; req = 8'b0011_1100;
      step();
      checks++; if (f_idx !== 3'd5 || f_valid !== 1'b1) begin failures++; $display("FAIL bp_first got_idx=%0d got_valid=%0b exp_idx=5 exp_valid=1", f_idx, f_valid); end
      req = 8'b0100_0000;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if (f_idx !== 3'd5 || f_oh !== 8'b0010_0000) begin failures++; $display("FAIL bp_stall c=%0d got_idx=%0d got_onehot=%b exp_idx=5", c, f_idx, f_oh); end
      end
      out_ready = 1'b1;
      step();
      checks++; if (f_idx !== 3'd6 || f_valid !== 1'b1) begin failures++; $display("FAIL bp_release got_idx=%0d got_valid=%0b exp_idx=6 exp_valid=1", f_idx, f_valid); end
   endtask

   task automatic test_empty();
      out_ready = 1'b1; req = 8'h00;
      step();
      checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL empty_valid got=%0b exp=0", f_valid); end
      checks++; if (f_idx !== 3'd0 || f_oh !== 8'h00) begin failures++; $display("FAIL empty_out got_idx=%0d got_onehot=%b exp=0", f_idx, f_oh); end
      checks++; if (f_any !== 1'b0) begin failures++; $display("FAIL empty_any got=%0b exp=0", f_any); end
      req = 8'b0000_0001;
      step();
      checks++; if (f_idx !== 3'd0 || f_valid !== 1'b1 || f_oh !== 8'b0000_0001) begin failures++; $display("FAIL empty_bit0 got_idx=%0d got_valid=%0b got_onehot=%b exp_idx=0 exp_valid=1", f_idx, f_valid, f_oh); end
      checks++; if (r_idx !== 3'd0 || r_valid !== 1'b1) begin failures++; $display("FAIL empty_bit0_rr got_idx=%0d got_valid=%0b exp_idx=0 exp_valid=1", r_idx, r_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 8'hFF; out_ready = 1'b1;
      step();
      checks++; if (r_idx !== 3'd7) begin failures++; $display("FAIL mid_g0 got=%0d exp=7", r_idx); end
      step();
      checks++; if (r_idx !== 3'd6) begin failures++; $display("FAIL mid_g1 got=%0d exp=6", r_idx); end
      rst = 1'b1;
      step();
      checks++; if (r_valid !== 1'b0 || r_any !== 1'b0) begin failures++; $display("FAIL mid_rst got_valid=%0b got_any=%0b exp=0", r_valid, r_any); end
      rst = 1'b0;
      step();
      checks++; if (r_idx !== 3'd7 || r_valid !== 1'b1) begin failures++; $display("FAIL mid_after got_idx=%0d got_valid=%0b exp_idx=7 exp_valid=1", r_idx, r_valid); end
   endtask

   task automatic test_sticky();
      logic seen3;
      seen3 = 1'b0;
      do_reset();
      out_ready = 1'b0; req = 8'b0011_1100;
      step();
      checks++; if (f_idx !== 3'd5) begin failures++; $display("FAIL sticky_hold got=%0d exp=5", f_idx); end
      req = 8'b0000_1000;
      step();
      req = 8'h00;
      step();
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         if (f_valid === 1'b1 && f_idx === 3'd3) seen3 = 1'b1;
      end
`ifdef PENC_STICKY_EN
      checks++; if (seen3 !== 1'b1) begin failures++; $display("FAIL sticky_grant3 got=%0b exp=1", seen3); end
      checks++; if (f_valid !== 1'b0 || f_any !== 1'b0) begin failures++; $display("FAIL sticky_drained got_valid=%0b got_any=%0b exp=0", f_valid, f_any); end
`else
      checks++; if (seen3 !== 1'b0) begin failures++; $display("FAIL nosticky_grant3 got=%0b exp=0", seen3); end
      checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL nosticky_idle got=%0b exp=0", f_valid); end
`endif
   endtask

   initial begin
      rst = 1'b1; req = '0; out_ready = 1'b1;
      test_reset();
      test_fixed();
      test_round_robin();
      test_backpressure();
      test_empty();
      test_reset_mid();
      test_sticky();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
